// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: cascaded h/v pixel counters producing registered
// hsync, vsync, data-enable, pixel coordinates and line/frame start strobes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | raster parked at (0,0), syncs inactive, de low
// ST_RUN   | raster advances one pixel per pix_ce, outputs follow (x,y)
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    input  logic           run,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT   = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_LAST = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT   = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_LAST = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t         state_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           hsync_q;
    logic           vsync_q;
    logic           de_q;
    logic           line_start_q;
    logic           frame_start_q;

    logic           x_last;
    logic           y_last;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;

    function automatic logic hs_level(input logic [X_W-1:0] xv);
        return (xv >= HS_BEG && xv <= HS_LAST) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vs_level(input logic [Y_W-1:0] yv);
        return (yv >= VS_BEG && yv <= VS_LAST) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic de_level(input logic [X_W-1:0] xv, input logic [Y_W-1:0] yv);
        return (xv < H_ACT) && (yv < V_ACT);
    endfunction

    // y only moves on the x wrap, so vsync (derived from y) spans whole lines
    always_comb begin
        x_last = (x_q == H_LAST);
        y_last = (y_q == V_LAST);
        x_d    = x_last ? '0 : x_q + X_W'(1);
        y_d    = y_q;
        if (x_last) begin
            y_d = y_last ? '0 : y_q + Y_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (!run) begin
                state_q <= ST_IDLE;
                x_q     <= '0;
                y_q     <= '0;
                hsync_q <= ~HS_POL;
                vsync_q <= ~VS_POL;
                de_q    <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (pix_ce) begin
                    state_q       <= ST_RUN;
                    x_q           <= '0;
                    y_q           <= '0;
                    hsync_q       <= hs_level('0);
                    vsync_q       <= vs_level('0);
                    de_q          <= de_level('0, '0);
                    line_start_q  <= 1'b1;
                    frame_start_q <= 1'b1;
                end
            end else if (pix_ce) begin
                x_q           <= x_d;
                y_q           <= y_d;
                hsync_q       <= hs_level(x_d);
                vsync_q       <= vs_level(y_d);
                de_q          <= de_level(x_d, y_d);
                line_start_q  <= x_last;
                frame_start_q <= x_last && y_last;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default 640x480 instance for line-level
// timing and a shrunken active-high-sync instance for whole-frame behaviour.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst, pix_ce, run;

    logic       hsa, vsa, dea, lsa, fsa;
    logic [9:0] xa, ya;
    logic       hsb, vsb, deb, lsb, fsb;
    logic [9:0] xb, yb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl dut_a (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .run(run),
        .hsync(hsa), .vsync(vsa), .de(dea), .x(xa), .y(ya),
        .line_start(lsa), .frame_start(fsa)
    );

    // 32x19 raster: hsync x=20..27, vsync y=14..15, 608 pixels per frame
    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .X_W(10), .Y_W(10)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .run(run),
        .hsync(hsb), .vsync(vsb), .de(deb), .x(xb), .y(yb),
        .line_start(lsb), .frame_start(fsb)
    );

    // reference raster model, index 0 = dut_a, 1 = dut_b
    int HT[2]  = '{800, 32};
    int VT[2]  = '{525, 19};
    int HA[2]  = '{640, 16};
    int HSS[2] = '{656, 20};
    int HSE[2] = '{752, 28};
    int VA[2]  = '{480, 12};
    int VSS[2] = '{490, 14};
    int VSE[2] = '{492, 16};
    bit HP[2]  = '{1'b0, 1'b1};
    bit VP[2]  = '{1'b0, 1'b1};
    int mst[2], mx[2], my[2], mls[2], mfs[2];

    int mm = 0;
    int range_bad = 0;
    int cyc = 0;
    int last_fs, fs_period, de_acc, de_frame, vs_min, vs_max, vs_bad, ls_run, ls_max;
    logic vsb_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        last_fs = -1; fs_period = 0; de_acc = 0; de_frame = 0;
        vs_min = 9999; vs_max = -1; vs_bad = 0; ls_run = 0; ls_max = 0;
    endtask

    task automatic tick();
        logic [31:0] ox[2], oy[2];
        logic        ohs[2], ovs[2], ode[2], ols[2], ofs[2];
        bit          ehs, evs, ede;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst || !run) begin
                mst[i] = 0; mx[i] = 0; my[i] = 0; mls[i] = 0; mfs[i] = 0;
            end else if (mst[i] == 0) begin
                mls[i] = pix_ce; mfs[i] = pix_ce;
                if (pix_ce) begin
                    mst[i] = 1; mx[i] = 0; my[i] = 0;
                end
            end else if (pix_ce) begin
                mx[i]++;
                if (mx[i] == HT[i]) begin
                    mx[i] = 0;
                    my[i]++;
                    if (my[i] == VT[i]) my[i] = 0;
                end
                mls[i] = (mx[i] == 0);
                mfs[i] = (mx[i] == 0 && my[i] == 0);
            end else begin
                mls[i] = 0; mfs[i] = 0;
            end
        end
        #1;
        cyc++;
        ox[0] = 32'(xa); oy[0] = 32'(ya); ohs[0] = hsa; ovs[0] = vsa; ode[0] = dea; ols[0] = lsa; ofs[0] = fsa;
        ox[1] = 32'(xb); oy[1] = 32'(yb); ohs[1] = hsb; ovs[1] = vsb; ode[1] = deb; ols[1] = lsb; ofs[1] = fsb;
        for (int i = 0; i < 2; i++) begin
            ehs = (mst[i] == 1 && mx[i] >= HSS[i] && mx[i] < HSE[i]) ? HP[i] : !HP[i];
            evs = (mst[i] == 1 && my[i] >= VSS[i] && my[i] < VSE[i]) ? VP[i] : !VP[i];
            ede = (mst[i] == 1 && mx[i] < HA[i] && my[i] < VA[i]);
            if (ox[i] !== 32'(mx[i]) || oy[i] !== 32'(my[i]) || ohs[i] !== ehs || ovs[i] !== evs ||
                ode[i] !== ede || ols[i] !== 1'(mls[i]) || ofs[i] !== 1'(mfs[i]))
                mm++;
            if (ox[i] >= 32'(HT[i]) || oy[i] >= 32'(VT[i])) range_bad++;
        end
        if (fsb) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs  = cyc;
            de_frame = de_acc;
            de_acc   = 0;
        end
        if (deb) de_acc++;
        if (vsb) begin
            if (int'(yb) < vs_min) vs_min = int'(yb);
            if (int'(yb) > vs_max) vs_max = int'(yb);
        end
        if (vsb !== vsb_prev && xb != 10'd0) vs_bad++;
        vsb_prev = vsb;
        ls_run = lsb ? ls_run + 1 : 0;
        if (ls_run > ls_max) ls_max = ls_run;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; pix_ce = 1'b1;
        clear_stats();
        ticks(3);
        chk("rst_x", 32'(xa), 0);
        chk("rst_y", 32'(ya), 0);
        chk("rst_hs_a", 32'(hsa), 1);
        chk("rst_vs_a", 32'(vsa), 1);
        chk("rst_de", 32'(dea), 0);
        chk("rst_strobes", {30'd0, lsa, fsa}, 0);
        chk("rst_hs_b", 32'(hsb), 0);
        chk("rst_vs_b", 32'(vsb), 0);

        rst = 1'b0;
        tick();
        chk("start_xy", {xa, ya}, 0);
        chk("start_de", 32'(dea), 1);
        chk("start_fs", 32'(fsa), 1);
        chk("start_ls", 32'(lsa), 1);
        tick();
        chk("start_strobe_clear", {30'd0, lsa, fsa}, 0);
        chk("start_x1", 32'(xa), 1);

        ticks(638);
        chk("x639", 32'(xa), 639);
        chk("de_x639", 32'(dea), 1);
        tick();
        chk("de_x640", 32'(dea), 0);
        ticks(15);
        chk("hs_x655", 32'(hsa), 1);
        tick();
        chk("hs_x656", 32'(hsa), 0);
        ticks(95);
        chk("hs_x751", {22'd0, xa}, 751);
        chk("hs_x751_lvl", 32'(hsa), 0);
        tick();
        chk("hs_x752", 32'(hsa), 1);
        ticks(47);
        chk("wrap_pre_xy", {xa, ya}, {10'd799, 10'd0});
        tick();
        chk("wrap_xy", {xa, ya}, {10'd0, 10'd1});
        chk("wrap_ls_fs", {30'd0, lsa, fsa}, 32'b10);
        chk("model_line", 32'(mm), 0);
        mm = 0;

        rst = 1'b1; tick(); rst = 1'b0;
        clear_stats();
        ticks(608 * 2 + 10);
        chk("frame_period_b", 32'(fs_period), 608);
        chk("frame_de_b", 32'(de_frame), 192);
        chk("vsync_min_y_b", 32'(vs_min), 14);
        chk("vsync_max_y_b", 32'(vs_max), 15);
        chk("vsync_mid_line_b", 32'(vs_bad), 0);
        chk("model_frame", 32'(mm), 0);
        mm = 0;

        rst = 1'b1; tick(); rst = 1'b0;
        clear_stats();
        for (int n = 0; n < 2432 * 2 + 6; n++) begin
            pix_ce = (n % 4 == 0);
            tick();
            if (n == 40) chk("ce4_x_n40", 32'(xa), 10);
            if (n == 43) chk("ce4_x_n43", 32'(xa), 10);
        end
        chk("ce4_frame_period_b", 32'(fs_period), 2432);
        chk("ce4_ls_width_b", 32'(ls_max), 1);
        chk("model_ce4", 32'(mm), 0);
        mm = 0;

        rst = 1'b1; pix_ce = 1'b1; tick(); rst = 1'b0;
        tick();
        ticks(345);
        chk("drop_pre_xy_b", {xb, yb}, {10'd25, 10'd10});
        chk("drop_pre_hs_b", 32'(hsb), 1);
        pix_ce = 1'b0; run = 1'b0;
        tick();
        chk("drop_xy_b", {xb, yb}, 0);
        chk("drop_sync_b", {30'd0, hsb, vsb}, 0);
        chk("drop_de_b", 32'(deb), 0);
        chk("drop_xy_a", {xa, ya}, 0);
        chk("drop_sync_a", {30'd0, hsa, vsa}, 32'b11);
        ticks(2);
        run = 1'b1;
        tick();
        chk("idle_hold_no_ce", {29'd0, deb, fsb, lsb}, 0);
        pix_ce = 1'b1;
        tick();
        chk("restart_fs_ls_b", {30'd0, fsb, lsb}, 32'b11);
        chk("restart_xy_b", {xb, yb}, 0);
        chk("restart_fs_a", 32'(fsa), 1);

        ticks(182);
        chk("mid_pre_xy_b", {xb, yb}, {10'd22, 10'd5});
        chk("mid_pre_hs_b", 32'(hsb), 1);
        chk("mid_pre_de_a", 32'(dea), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_xy", {xa, ya, xb, yb}, 0);
        chk("mid_rst_syncs", {28'd0, hsa, vsa, hsb, vsb}, 32'b1100);
        chk("mid_rst_de_strobes", {26'd0, dea, lsa, fsa, deb, lsb, fsb}, 0);
        rst = 1'b0; run = 1'b0;
        tick();
        chk("model_tail", 32'(mm), 0);
        chk("counter_range", 32'(range_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
